mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit_pkg.sv | 74 +++++++
 rtl/mem_access_unit_lsu_lane_align.sv | 74 +++++++
 rtl/mem_access_unit.sv | 137 +++++++++++++
 tb/tb_mem_access_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-access stage: op encodings, byte-lane
// constants, default widths, FSM states and the op decoder.
package mem_access_unit_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic      is_load;
        logic      is_store;
        logic      sign_ext;
        mem_size_e size;
    } op_info_t;

    // Big-endian lanes: byte offset 0 lives in bits 31:24, i.e. sel[3].
    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_B0   = 4'b1000;
    localparam logic [3:0] SEL_B1   = 4'b0100;
    localparam logic [3:0] SEL_B2   = 4'b0010;
    localparam logic [3:0] SEL_B3   = 4'b0001;
    localparam logic [3:0] SEL_H0   = 4'b1100;
    localparam logic [3:0] SEL_H1   = 4'b0011;
    localparam logic [3:0] SEL_W    = 4'b1111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

    // Unused encodings 9..15 fall through to NONE.
    function automatic op_info_t decode_op(input logic [3:0] op);
        op_info_t info;
        info = '{is_load: 1'b0, is_store: 1'b0, sign_ext: 1'b0, size: SZ_B};
        case (op)
            OP_LB:   info = '{is_load: 1'b1, is_store: 1'b0, sign_ext: 1'b1, size: SZ_B};
            OP_LBU:  info = '{is_load: 1'b1, is_store: 1'b0, sign_ext: 1'b0, size: SZ_B};
            OP_LH:   info = '{is_load: 1'b1, is_store: 1'b0, sign_ext: 1'b1, size: SZ_H};
            OP_LHU:  info = '{is_load: 1'b1, is_store: 1'b0, sign_ext: 1'b0, size: SZ_H};
            OP_LW:   info = '{is_load: 1'b1, is_store: 1'b0, sign_ext: 1'b0, size: SZ_W};
            OP_SB:   info = '{is_load: 1'b0, is_store: 1'b1, sign_ext: 1'b0, size: SZ_B};
            OP_SH:   info = '{is_load: 1'b0, is_store: 1'b1, sign_ext: 1'b0, size: SZ_H};
            OP_SW:   info = '{is_load: 1'b0, is_store: 1'b1, sign_ext: 1'b0, size: SZ_W};
            default: ;
        endcase
        return info;
    endfunction

    function automatic logic is_aligned(input mem_size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_H:    return ~addr_lo[0];
            SZ_W:    return (addr_lo == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lsu_lane_align.sv
// Combinational byte-lane steering: store lane select/replication and
// load lane extraction with sign or zero extension.
module lsu_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic        is_load,
    output logic        is_store,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic        aligned,
    output logic [31:0] ldata
);

    op_info_t   info;
    logic [7:0] byte_v;
    logic [15:0] half_v;

    assign info     = decode_op(op);
    assign is_load  = info.is_load;
    assign is_store = info.is_store;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can infer a latch.
    always_comb begin
        sel     = SEL_NONE;
        wdata   = '0;
        aligned = 1'b1;
        if (info.is_load || info.is_store) begin
            aligned = is_aligned(info.size, addr_lo);
            case (info.size)
                SZ_B: begin
                    case (addr_lo)
                        2'd0:    sel = SEL_B0;
                        2'd1:    sel = SEL_B1;
                        2'd2:    sel = SEL_B2;
                        default: sel = SEL_B3;
                    endcase
                    wdata = {4{sdata[7:0]}};
                end
                SZ_H: begin
                    sel   = addr_lo[1] ? SEL_H1 : SEL_H0;
                    wdata = {2{sdata[15:0]}};
                end
                default: begin
                    sel   = SEL_W;
                    wdata = sdata;
                end
            endcase
            if (!info.is_store) begin
                wdata = '0;
            end
        end
    end

    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = rdata[31:24];
            2'd1:    byte_v = rdata[23:16];
            2'd2:    byte_v = rdata[15:8];
            default: byte_v = rdata[7:0];
        endcase
        half_v = addr_lo[1] ? rdata[15:0] : rdata[31:16];
        case (info.size)
            SZ_B:    ldata = info.sign_ext ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
            SZ_H:    ldata = info.sign_ext ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: drives the data RAM, registers the result
// toward write-back and traps misaligned accesses until flushed.
module mem_access_unit #(
    parameter int ADDR_W = mem_access_unit_pkg::ADDR_W,
    parameter int DATA_W = mem_access_unit_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [3:0]        ex_op,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_sdata,
    input  logic [4:0]        ex_wd,
    input  logic              ex_wreg,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_sel,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [4:0]        wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              exc_valid,
    output logic [ADDR_W-1:0] exc_badaddr,
    output logic              exc_store
);

    import mem_access_unit_pkg::*;

    state_e            state_q;
    state_e            state_d;
    logic              is_load;
    logic              is_store;
    logic              mem_op;
    logic              lane_aligned;
    logic [3:0]        lane_sel;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_ldata;
    logic              fire;
    logic              trap_take;
    logic [DATA_W-1:0] result;

    lsu_lane_align u_lane_align (
        .op       (ex_op),
        .addr_lo  (ex_addr[1:0]),
        .sdata    (ex_sdata),
        .rdata    (ram_rdata),
        .is_load  (is_load),
        .is_store (is_store),
        .sel      (lane_sel),
        .wdata    (lane_wdata),
        .aligned  (lane_aligned),
        .ldata    (lane_ldata)
    );

    assign mem_op = is_load | is_store;

    // Gating with rst_n keeps every RAM strobe low while reset is held.
    assign ex_ready  = rst_n & (state_q == ST_RUN) & (~wb_valid | wb_ready);
    assign fire      = ex_valid & ex_ready & ~flush;
    assign trap_take = fire & mem_op & ~lane_aligned;

    assign ram_ce    = fire & mem_op & lane_aligned;
    assign ram_we    = ram_ce & is_store;
    assign ram_addr  = ram_ce ? ex_addr    : '0;
    assign ram_sel   = ram_ce ? lane_sel   : SEL_NONE;
    assign ram_wdata = ram_ce ? lane_wdata : '0;

    assign result = is_load  ? lane_ldata :
                    is_store ? '0         : ex_wdata;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (trap_take) state_d = ST_TRAP;
            ST_TRAP: if (flush)     state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
        if (flush) begin
            state_d = ST_RUN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Load data is sampled at the accepting edge, so the RAM read is combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_wd    <= '0;
            wb_wreg  <= 1'b0;
            wb_wdata <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (trap_take) begin
            wb_valid <= 1'b0;
        end else if (fire) begin
            wb_valid <= 1'b1;
            wb_wd    <= ex_wd;
            wb_wreg  <= ex_wreg & ~is_store;
            wb_wdata <= result;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_valid   <= 1'b0;
            exc_badaddr <= '0;
            exc_store   <= 1'b0;
        end else if (flush) begin
            exc_valid   <= 1'b0;
            exc_badaddr <= '0;
            exc_store   <= 1'b0;
        end else if (trap_take) begin
            exc_valid   <= 1'b1;
            exc_badaddr <= ex_addr;
            exc_store   <= is_store;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-level memory model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [3:0]  ex_op = 4'd0;
    logic [31:0] ex_addr = '0;
    logic [31:0] ex_sdata = '0;
    logic [4:0]  ex_wd = '0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_wdata = '0;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata, ram_rdata;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        exc_valid;
    logic [31:0] exc_badaddr;
    logic        exc_store;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_addr(ex_addr),
        .ex_sdata(ex_sdata), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
        .wb_wdata(wb_wdata), .exc_valid(exc_valid), .exc_badaddr(exc_badaddr),
        .exc_store(exc_store)
    );

    // Word RAM covering 0x100..0x13F, combinational read, lane-masked write.
    logic [31:0] ram_mem [16];
    assign ram_rdata = ram_mem[ram_addr[5:2]];
    always @(posedge clk) begin
        if (ram_we) begin
            for (int k = 0; k < 4; k++) begin
                if (ram_sel[3-k]) ram_mem[ram_addr[5:2]][31-8*k -: 8] <= ram_wdata[31-8*k -: 8];
            end
        end
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory as individual bytes, big-endian byte order.
    logic [7:0]  m_bytes [64];
    logic        m_valid = 1'b0, m_is_store = 1'b0, m_wreg = 1'b0;
    logic        m_exc = 1'b0, m_exc_store = 1'b0, m_trap = 1'b0;
    logic [4:0]  m_wd = '0;
    logic [31:0] m_wdata = '0, m_badaddr = '0;
    logic        cmp_en = 1'b0;
    logic [3:0]  obs_sel;
    logic [31:0] obs_wdata;
    logic        obs_ce, obs_we, obs_ready;

    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    initial forever begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
            m_valid = 1'b0; m_exc = 1'b0; m_trap = 1'b0;
        end else begin
            int          size, base;
            bit          st, mem, al, rdy, fire;
            logic [3:0]  esel;
            logic [31:0] ewd, v;
            obs_sel = ram_sel; obs_wdata = ram_wdata; obs_ce = ram_ce;
            obs_we = ram_we; obs_ready = ex_ready;
            size = op_size(ex_op);
            mem  = (size != 0);
            st   = (ex_op >= 4'd6 && ex_op <= 4'd8);
            al   = !mem || ((int'(ex_addr[1:0]) % size) == 0);
            rdy  = !m_trap && (!m_valid || wb_ready);
            fire = ex_valid && rdy && !flush;
            base = int'(ex_addr[5:0]);
            if (cmp_en) begin
                check("wb_valid", wb_valid, m_valid);
                if (m_valid) begin
                    check("wb_wd", wb_wd, m_wd);
                    check("wb_wreg", wb_wreg, m_wreg);
                    if (!m_is_store) check("wb_wdata", wb_wdata, m_wdata);
                end
                check("exc_valid", exc_valid, m_exc);
                if (m_exc) begin
                    check("exc_badaddr", exc_badaddr, m_badaddr);
                    check("exc_store", exc_store, m_exc_store);
                end
                check("ex_ready", ex_ready, rdy);
                check("ram_ce", ram_ce, fire && mem && al);
                check("ram_we", ram_we, fire && mem && al && st);
                if (fire && mem && al) begin
                    esel = '0;
                    for (int i = 0; i < size; i++) esel[3 - (int'(ex_addr[1:0]) + i)] = 1'b1;
                    check("ram_addr", ram_addr, ex_addr);
                    check("ram_sel", ram_sel, esel);
                    if (st) begin
                        ewd = (size == 1) ? {4{ex_sdata[7:0]}} :
                              (size == 2) ? {2{ex_sdata[15:0]}} : ex_sdata;
                        check("ram_wdata", ram_wdata, ewd);
                    end
                end else begin
                    check("ram_sel_idle", ram_sel, 4'b0000);
                    check("ram_addr_idle", ram_addr, 32'h0);
                end
            end
            if (flush) begin
                m_valid = 1'b0; m_exc = 1'b0; m_trap = 1'b0;
            end else if (fire && !al) begin
                m_trap = 1'b1; m_exc = 1'b1; m_badaddr = ex_addr;
                m_exc_store = st; m_valid = 1'b0;
            end else if (fire) begin
                m_valid = 1'b1; m_wd = ex_wd; m_wreg = ex_wreg && !st; m_is_store = st;
                if (st) begin
                    for (int i = 0; i < size; i++) m_bytes[base + i] = ex_sdata[8*(size-1-i) +: 8];
                end else if (mem) begin
                    v = '0;
                    for (int i = 0; i < size; i++) v = (v << 8) | 32'(m_bytes[base + i]);
                    if (ex_op == 4'd1) v = {{24{v[7]}}, v[7:0]};
                    if (ex_op == 4'd3) v = {{16{v[15]}}, v[15:0]};
                    m_wdata = v;
                end else begin
                    m_wdata = ex_wdata;
                end
            end else if (wb_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic drive(input bit v, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sd, input bit rdy, input bit fl);
        ex_valid = v; ex_op = op; ex_addr = addr; ex_sdata = sd;
        wb_ready = rdy; flush = fl;
        ex_wd = 5'($urandom); ex_wreg = 1'($urandom); ex_wdata = $urandom;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wb_valid"}, wb_valid, 32'h0);
        check({tag, "_wb_wd"}, wb_wd, 32'h0);
        check({tag, "_wb_wreg"}, wb_wreg, 32'h0);
        check({tag, "_wb_wdata"}, wb_wdata, 32'h0);
        check({tag, "_exc_valid"}, exc_valid, 32'h0);
        check({tag, "_exc_badaddr"}, exc_badaddr, 32'h0);
        check({tag, "_exc_store"}, exc_store, 32'h0);
        check({tag, "_ex_ready"}, ex_ready, 32'h0);
        check({tag, "_ram_ce"}, ram_ce, 32'h0);
        check({tag, "_ram_we"}, ram_we, 32'h0);
        check({tag, "_ram_sel"}, ram_sel, 32'h0);
        check({tag, "_ram_addr"}, ram_addr, 32'h0);
        check({tag, "_ram_wdata"}, ram_wdata, 32'h0);
    endtask

    task automatic async_reset(input string tag);
        cmp_en = 1'b0;
        ex_valid = 1'b1; ex_op = 4'd6; ex_addr = 32'h110; wb_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all_zero(tag);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ex_valid = 1'b0;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) m_bytes[i] = 8'($urandom);
        for (int w = 0; w < 16; w++)
            ram_mem[w] = {m_bytes[4*w], m_bytes[4*w+1], m_bytes[4*w+2], m_bytes[4*w+3]};

        ex_valid = 1'b1; ex_op = 4'd8; ex_addr = 32'h100;
        #1 check_all_zero("reset");
        ex_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;

        drive(1, 4'd8, 32'h100, 32'h11223344, 1, 0);
        check("sw_sel", obs_sel, 4'b1111);
        check("sw_we", obs_we, 1'b1);
        drive(1, 4'd1, 32'h100, 32'h0, 1, 0);
        check("lb_100", wb_wdata, 32'h00000011);
        drive(1, 4'd2, 32'h103, 32'h0, 1, 0);
        check("lbu_103", wb_wdata, 32'h00000044);
        drive(1, 4'd3, 32'h102, 32'h0, 1, 0);
        check("lh_102", wb_wdata, 32'h00003344);

        drive(1, 4'd6, 32'h101, 32'h000000F0, 1, 0);
        check("sb_sel", obs_sel, 4'b0100);
        check("sb_wdata", obs_wdata, 32'hF0F0F0F0);
        drive(1, 4'd1, 32'h101, 32'h0, 1, 0);
        check("lb_101", wb_wdata, 32'hFFFFFFF0);
        drive(1, 4'd2, 32'h101, 32'h0, 1, 0);
        check("lbu_101", wb_wdata, 32'h000000F0);

        drive(1, 4'd5, 32'h102, 32'h0, 1, 0);
        check("mis_ce", obs_ce, 1'b0);
        check("mis_exc_valid", exc_valid, 1'b1);
        check("mis_badaddr", exc_badaddr, 32'h102);
        check("mis_store", exc_store, 1'b0);
        check("mis_wb_valid", wb_valid, 1'b0);
        repeat (2) begin
            drive(1, 4'd5, 32'h100, 32'h0, 1, 0);
            check("trap_ready", obs_ready, 1'b0);
            check("trap_ce", obs_ce, 1'b0);
        end
        drive(0, 4'd0, 32'h0, 32'h0, 1, 1);
        check("flush_exc", exc_valid, 1'b0);
        check("flush_ready", ex_ready, 1'b1);

        drive(1, 4'd5, 32'h100, 32'h0, 0, 0);
        check("bp_wdata0", wb_wdata, 32'h11F03344);
        repeat (3) begin
            drive(1, 4'd8, 32'h104, 32'hCAFEF00D, 0, 0);
            check("bp_ready", obs_ready, 1'b0);
            check("bp_ce", obs_ce, 1'b0);
            check("bp_stable", wb_wdata, 32'h11F03344);
        end
        drive(1, 4'd8, 32'h104, 32'hCAFEF00D, 1, 0);
        check("rel_ready0", obs_ready, 1'b1);
        check("rel_we", obs_we, 1'b1);
        drive(1, 4'd5, 32'h104, 32'h0, 1, 0);
        check("rel_ready1", obs_ready, 1'b1);
        check("rel_lw", wb_wdata, 32'hCAFEF00D);
        drive(1, 4'd1, 32'h106, 32'h0, 1, 0);
        check("rel_ready2", obs_ready, 1'b1);
        check("rel_lb", wb_wdata, 32'hFFFFFFF0);

        drive(1, 4'd8, 32'h108, 32'h5A5A5A5A, 1, 0);
        drive(1, 4'd8, 32'h108, 32'hDEADBEEF, 1, 1);
        check("fl_we", obs_we, 1'b0);
        check("fl_wb_valid", wb_valid, 1'b0);
        drive(1, 4'd5, 32'h108, 32'h0, 1, 0);
        check("fl_old", wb_wdata, 32'h5A5A5A5A);

        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a;
            a = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) < 6) a[1:0] = 2'b00;
            drive($urandom_range(0, 9) < 8, 4'($urandom_range(0, 15)), a, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end

        drive(0, 4'd0, 32'h0, 32'h0, 1, 1);
        drive(1, 4'd5, 32'h100, 32'h0, 0, 0);
        check("rst_hold_valid", wb_valid, 1'b1);
        async_reset("rst_wb");
        drive(1, 4'd3, 32'h101, 32'h0, 1, 0);
        check("rst_trap_exc", exc_valid, 1'b1);
        async_reset("rst_trap");

        for (int c = 0; c < 200; c++) begin
            drive($urandom_range(0, 1) == 1, 4'($urandom_range(0, 8)),
                  32'h100 + 32'($urandom_range(0, 15) * 4), $urandom,
                  $urandom_range(0, 3) != 0, 1'b0);
        end
        drive(0, 4'd0, 32'h0, 32'h0, 1, 1);
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
